ga_mutation_unit: RTL and testbench
===================================

// Module: ga_mutation_unit
// PURPOSE
//   Genetic-algorithm mutation stage; sits directly downstream of the LSFR random generator.
//   Takes one chromosome and walks its genes serially, drawing randomness from the LSFR for each gene:
//     - 8-bit draw (mode 2): decides whether the gene mutates.
//     - 2-bit draw (mode 1): picks which bit of the gene flips.
//   Returns the mutated chromosome and the mutation count to the GA controller.
// PARAMETERS
//   S_WIDTH     8   width of LSFR byte value (random_num_ff_02_o)
//   INT_WIDTH   2   width of LSFR int value (random_num_ff_1_o); bit-select width
//   GENE_WIDTH  4   bits per gene; must equal 2**INT_WIDTH
//   N_GENES     8   genes per chromosome; CW = N_GENES*GENE_WIDTH (32)
// PORTS
//   clk_i        in   1          clock, rising edge
//   rst_i        in   1          synchronous reset, active-high
//   start_i      in   1          request; accepted only in IDLE
//   chrom_i      in   CW         input chromosome; gene g = bits [g*GENE_WIDTH +: GENE_WIDTH]
//   rate_i       in   S_WIDTH    mutation threshold; gene mutates iff draw < rate
//   rng_byte_i   in   S_WIDTH    from LSFR random_num_ff_02_o
//   rng_int_i    in   INT_WIDTH  from LSFR random_num_ff_1_o
//   rng_mode_o   out  2          to LSFR mode_i (0 hold, 1 int, 2 byte)
//   busy_o       out  1          high from accept until DONE (inclusive)
//   done_o       out  1          one-cycle pulse; chrom_o/mut_cnt_o valid
//   chrom_o      out  CW         mutated chromosome; held until next accept
//   mut_cnt_o    out  $clog2(N_GENES+1)  genes mutated in this run
// BEHAVIOUR
//   Reset (rst_i=1 at a clock edge), regardless of state:
//     - state=IDLE; all outputs 0 (rng_mode_o=0, chrom_o=0); gene_idx=0.
//     - A run in progress is abandoned: no done_o.
//   LSFR contract: a value requested with rng_mode_o=M in cycle t is sampled from the matching output in cycle t+1.
//   States:
//     IDLE  - rng_mode_o=0. On start_i=1: latch chrom_i->work_r, rate_i->rate_r; clear mut_cnt; gene_idx=0; busy_o=1; ->PROB.
//     PROB  - rng_mode_o=2; ->POS.
//     POS   - rng_mode_o=1; latch rng_byte_i->prob_r; ->APPLY.
//     APPLY - rng_mode_o=0; latch rng_int_i->pos.
//             If prob_r < rate_r: flip work_r[gene_idx*GENE_WIDTH+pos]; mut_cnt++.
//             If gene_idx==N_GENES-1: ->DONE, else gene_idx++, ->PROB.
//     DONE  - chrom_o<=work_r, mut_cnt_o<=mut_cnt, done_o=1 for exactly one cycle; ->IDLE (busy_o low next cycle).
//   Comparison is unsigned:
//     - rate 0: never mutates.
//     - rate 255: mutates unless draw==255.
//   Exactly one bit flips per mutated gene; other genes pass through unchanged.
//   Latency: start accept edge -> done_o high = 3*N_GENES+1 cycles (25 with defaults).
//   Next start is accepted the cycle after DONE.
//   start_i while busy_o=1: ignored; no queuing; latched inputs unaffected.
//   chrom_i/rate_i changes after accept: no effect on current run.
//   mut_cnt saturates never: max N_GENES fits its width.
//   No reseeding: random_seed_valid_i of LSFR is owned by the controller.
// TESTING
//   1 rst_i held 2 cycles mid-run (gene 3) -> IDLE, all outputs 0, no done_o; fresh start then completes normally.
//   2 rate_i=0, chrom_i=32'hDEADBEEF, any stub draws -> done_o after 25 cycles, chrom_o=32'hDEADBEEF, mut_cnt_o=0.
//   3 rate_i=8'hFF, stub byte=8'h00, int=2'd0 every draw, chrom_i=0 -> chrom_o=32'h11111111, mut_cnt_o=8.
//   4 rate_i=8'h80, chrom_i=0, stub byte=8'h7F for even genes / 8'h80 for odd, int=2'd3 ->
//     chrom_o=32'h08080808, mut_cnt_o=4; threshold boundary checked.
//   5 start_i re-pulsed at cycles 5 and 24 with different chrom_i -> ignored; result matches first request; busy_o high 26 cycles.
//   6 back-to-back: start_i held high -> second run accepted the cycle after done_o;
//     rng_mode_o sequence 2,1,0 per gene checked against scoreboard.

Source files
------------

// File: rtl/ga_mutation_unit.sv
// Genetic-algorithm mutation stage: walks the genes of one chromosome serially,
// drawing a mutate/no-mutate byte and a bit-select from the LSFR per gene.
module ga_mutation_unit #(
    parameter int unsigned S_WIDTH    = 8,
    parameter int unsigned INT_WIDTH  = 2,
    parameter int unsigned GENE_WIDTH = 4,
    parameter int unsigned N_GENES    = 8,
    localparam int unsigned CW        = N_GENES * GENE_WIDTH,
    localparam int unsigned CNT_W     = $clog2(N_GENES + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CW-1:0]        chrom_i,
    input  logic [S_WIDTH-1:0]   rate_i,
    input  logic [S_WIDTH-1:0]   rng_byte_i,
    input  logic [INT_WIDTH-1:0] rng_int_i,
    output logic [1:0]           rng_mode_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CW-1:0]        chrom_o,
    output logic [CNT_W-1:0]     mut_cnt_o
);

    localparam int unsigned GIW   = (N_GENES > 1) ? $clog2(N_GENES) : 1;
    localparam int unsigned IDX_W = GIW + INT_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROB,
        S_POS,
        S_APPLY,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CW-1:0]      work_r;
    logic [S_WIDTH-1:0] rate_r;
    logic [S_WIDTH-1:0] prob_r;
    logic [GIW-1:0]     gene_idx;
    logic [CNT_W-1:0]   mut_cnt;
    logic [1:0]         mode_d;
    logic               busy_d;
    logic               done_d;
    logic               last_gene;
    logic [IDX_W-1:0]   flip_idx;
    logic [CW-1:0]      flip_mask;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign last_gene = (gene_idx == GIW'(N_GENES - 1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_PROB;
            S_PROB:  state_d = S_POS;
            S_POS:   state_d = S_APPLY;
            S_APPLY: state_d = last_gene ? S_DONE : S_PROB;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; the mode tracks the state so the LSFR answers one cycle later
    always_comb begin
        mode_d = 2'd0;
        case (state_d)
            S_PROB:  mode_d = 2'd2;
            S_POS:   mode_d = 2'd1;
            default: mode_d = 2'd0;
        endcase
        busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
        done_d = (state_q == S_DONE);
    end

    // Gene bit index: gene_idx*GENE_WIDTH + pos, with GENE_WIDTH == 2**INT_WIDTH
    assign flip_idx  = {gene_idx, rng_int_i};
    assign flip_mask = CW'(1) << flip_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rng_mode_o <= 2'd0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            chrom_o    <= '0;
            mut_cnt_o  <= '0;
            work_r     <= '0;
            rate_r     <= '0;
            prob_r     <= '0;
            gene_idx   <= '0;
            mut_cnt    <= '0;
        end else begin
            rng_mode_o <= mode_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        work_r   <= chrom_i;
                        rate_r   <= rate_i;
                        mut_cnt  <= '0;
                        gene_idx <= '0;
                    end
                end
                S_POS: prob_r <= rng_byte_i;
                S_APPLY: begin
                    if (prob_r < rate_r) begin
                        work_r  <= work_r ^ flip_mask;
                        mut_cnt <= mut_cnt + 1'b1;
                    end
                    if (!last_gene) begin
                        gene_idx <= gene_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    chrom_o   <= work_r;
                    mut_cnt_o <= mut_cnt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ga_mutation_unit.sv
// Directed bench for ga_mutation_unit with a small LSFR stub answering the
// mode requests one cycle later.
module tb_ga_mutation_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] chrom_i;
    logic [7:0]  rate_i;
    logic [7:0]  rng_byte_i = 8'h00;
    logic [1:0]  rng_int_i  = 2'd0;
    logic [1:0]  rng_mode_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] chrom_o;
    logic [3:0]  mut_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] byte_even = 8'h00;
    logic [7:0] byte_odd  = 8'h00;
    logic [1:0] int_val   = 2'd0;
    int         draw_cnt  = 0;

    ga_mutation_unit dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .chrom_i    (chrom_i),
        .rate_i     (rate_i),
        .rng_byte_i (rng_byte_i),
        .rng_int_i  (rng_int_i),
        .rng_mode_o (rng_mode_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .chrom_o    (chrom_o),
        .mut_cnt_o  (mut_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // LSFR stub: byte draws alternate even/odd gene values within a run
    always @(posedge clk_i) begin
        if (busy_o !== 1'b1) begin
            draw_cnt <= 0;
        end else if (rng_mode_o == 2'd2) begin
            rng_byte_i <= draw_cnt[0] ? byte_odd : byte_even;
            draw_cnt   <= draw_cnt + 1;
        end
        if (rng_mode_o == 2'd1) rng_int_i <= int_val;
    end

    task automatic do_run(input logic [31:0] c, input logic [7:0] r, output int lat);
        @(negedge clk_i);
        start_i = 1'b1;
        chrom_i = c;
        rate_i  = r;
        @(negedge clk_i);
        start_i = 1'b0;
        chrom_i = ~c;
        rate_i  = ~r;
        lat = 0;
        while (done_o !== 1'b1 && lat < 100) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; start_i = 1'b0; chrom_i = '0; rate_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_vec++;
        if ({rng_mode_o, busy_o, done_o, chrom_o, mut_cnt_o} !== 40'h0) begin
            n_err++;
            $display("FAIL reset_outputs got mode=%0d busy=%b done=%b chrom=%h cnt=%0d exp all 0",
                     rng_mode_o, busy_o, done_o, chrom_o, mut_cnt_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_rate_zero;
        int lat;
        byte_even = 8'h00; byte_odd = 8'h55; int_val = 2'd1;
        do_run(32'hDEADBEEF, 8'h00, lat);
        n_vec++;
        if (lat !== 25) begin n_err++; $display("FAIL rate0_latency got %0d exp 25", lat); end
        n_vec++;
        if (chrom_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL rate0_chrom got %h exp deadbeef", chrom_o); end
        n_vec++;
        if (mut_cnt_o !== 4'd0) begin n_err++; $display("FAIL rate0_cnt got %0d exp 0", mut_cnt_o); end
        n_vec++;
        if (busy_o !== 1'b1) begin n_err++; $display("FAIL rate0_busy_at_done got %b exp 1", busy_o); end
        @(negedge clk_i);
        n_vec++;
        if ({done_o, busy_o} !== 2'b00) begin
            n_err++; $display("FAIL rate0_after_done got done=%b busy=%b exp 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_rate_max;
        int lat;
        byte_even = 8'h00; byte_odd = 8'h00; int_val = 2'd0;
        do_run(32'h0, 8'hFF, lat);
        n_vec++;
        if (chrom_o !== 32'h11111111) begin n_err++; $display("FAIL ratemax_chrom got %h exp 11111111", chrom_o); end
        n_vec++;
        if (mut_cnt_o !== 4'd8) begin n_err++; $display("FAIL ratemax_cnt got %0d exp 8", mut_cnt_o); end
    endtask

    task automatic test_threshold;
        int lat;
        byte_even = 8'h7F; byte_odd = 8'h80; int_val = 2'd3;
        do_run(32'h0, 8'h80, lat);
        n_vec++;
        if (chrom_o !== 32'h08080808) begin n_err++; $display("FAIL thresh80_chrom got %h exp 08080808", chrom_o); end
        n_vec++;
        if (mut_cnt_o !== 4'd4) begin n_err++; $display("FAIL thresh80_cnt got %0d exp 4", mut_cnt_o); end
        // draw 255 never mutates even at the maximum rate
        byte_even = 8'hFF; byte_odd = 8'h00; int_val = 2'd0;
        do_run(32'h0, 8'hFF, lat);
        n_vec++;
        if (chrom_o !== 32'h10101010) begin n_err++; $display("FAIL threshff_chrom got %h exp 10101010", chrom_o); end
        n_vec++;
        if (mut_cnt_o !== 4'd4) begin n_err++; $display("FAIL threshff_cnt got %0d exp 4", mut_cnt_o); end
    endtask

    task automatic test_mid_run_reset;
        int lat;
        int dones = 0;
        byte_even = 8'h00; byte_odd = 8'h00; int_val = 2'd2;
        @(negedge clk_i);
        start_i = 1'b1; chrom_i = 32'h0; rate_i = 8'hFF;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        n_vec++;
        if ({rng_mode_o, busy_o, done_o, chrom_o, mut_cnt_o} !== 40'h0) begin
            n_err++;
            $display("FAIL midreset_outputs got mode=%0d busy=%b done=%b chrom=%h cnt=%0d exp all 0",
                     rng_mode_o, busy_o, done_o, chrom_o, mut_cnt_o);
        end
        rst_i = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_i);
            if (done_o === 1'b1 || busy_o === 1'b1) dones++;
        end
        n_vec++;
        if (dones !== 0) begin n_err++; $display("FAIL midreset_no_done got %0d active cycles exp 0", dones); end
        byte_even = 8'h00; byte_odd = 8'hFF; int_val = 2'd2;
        do_run(32'h0, 8'h80, lat);
        n_vec++;
        if (lat !== 25) begin n_err++; $display("FAIL midreset_rerun_latency got %0d exp 25", lat); end
        n_vec++;
        if (chrom_o !== 32'h04040404 || mut_cnt_o !== 4'd4) begin
            n_err++; $display("FAIL midreset_rerun got chrom=%h cnt=%0d exp 04040404 4", chrom_o, mut_cnt_o);
        end
    endtask

    task automatic test_ignore_start;
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_lat = -1;
        logic [31:0] res_chrom = '0;
        logic [3:0]  res_cnt = '0;
        byte_even = 8'h00; byte_odd = 8'h00; int_val = 2'd1;
        @(negedge clk_i);
        start_i = 1'b1; chrom_i = 32'h0; rate_i = 8'hFF;
        @(negedge clk_i);
        for (int k = 0; k < 40; k++) begin
            if (busy_o === 1'b1) busy_cnt++;
            if (done_o === 1'b1) begin
                done_cnt++; done_lat = k; res_chrom = chrom_o; res_cnt = mut_cnt_o;
            end
            start_i = (k == 5 || k == 24);
            chrom_i = start_i ? 32'hFFFFFFFF : 32'h0;
            rate_i  = start_i ? 8'h00 : 8'hFF;
            @(negedge clk_i);
        end
        n_vec++;
        if (busy_cnt !== 26) begin n_err++; $display("FAIL ignore_busy_cycles got %0d exp 26", busy_cnt); end
        n_vec++;
        if (done_cnt !== 1 || done_lat !== 25) begin
            n_err++; $display("FAIL ignore_done got count=%0d at=%0d exp 1 at 25", done_cnt, done_lat);
        end
        n_vec++;
        if (res_chrom !== 32'h22222222 || res_cnt !== 4'd8) begin
            n_err++; $display("FAIL ignore_result got chrom=%h cnt=%0d exp 22222222 8", res_chrom, res_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int kk;
        logic [1:0] exp_mode;
        logic       exp_done;
        int mode_err = 0;
        int flag_err = 0;
        byte_even = 8'h00; byte_odd = 8'h00; int_val = 2'd2;
        @(negedge clk_i);
        start_i = 1'b1; chrom_i = 32'h0; rate_i = 8'hFF;
        @(negedge clk_i);
        for (int k = 0; k < 52; k++) begin
            kk = (k < 26) ? k : k - 26;
            if (kk >= 24)         exp_mode = 2'd0;
            else if (kk % 3 == 0) exp_mode = 2'd2;
            else if (kk % 3 == 1) exp_mode = 2'd1;
            else                  exp_mode = 2'd0;
            exp_done = (k == 25 || k == 51);
            n_vec++;
            if (rng_mode_o !== exp_mode) begin
                n_err++; mode_err++;
                if (mode_err <= 4) $display("FAIL b2b_mode k=%0d got %0d exp %0d", k, rng_mode_o, exp_mode);
            end
            n_vec++;
            if ({busy_o, done_o} !== {1'b1, exp_done}) begin
                n_err++; flag_err++;
                if (flag_err <= 4) $display("FAIL b2b_flags k=%0d got busy=%b done=%b exp 1 %b", k, busy_o, done_o, exp_done);
            end
            if (k == 25) begin
                n_vec++;
                if (chrom_o !== 32'h44444444 || mut_cnt_o !== 4'd8) begin
                    n_err++; $display("FAIL b2b_first got chrom=%h cnt=%0d exp 44444444 8", chrom_o, mut_cnt_o);
                end
            end
            if (k == 1)  chrom_i = 32'h44444444;
            if (k == 26) start_i = 1'b0;
            @(negedge clk_i);
        end
        n_vec++;
        if (chrom_o !== 32'h0 || mut_cnt_o !== 4'd8) begin
            n_err++; $display("FAIL b2b_second got chrom=%h cnt=%0d exp 00000000 8", chrom_o, mut_cnt_o);
        end
        n_vec++;
        if ({busy_o, done_o} !== 2'b00) begin
            n_err++; $display("FAIL b2b_idle got busy=%b done=%b exp 0 0", busy_o, done_o);
        end
    endtask

    initial begin
        test_reset;
        test_rate_zero;
        test_rate_max;
        test_threshold;
        test_mid_run_reset;
        test_ignore_start;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
